// File: rtl/udma_i2c_cmd_enc_if.sv
// Request and command-stream bundle for the uDMA I2C command encoder.
// The slave modport is the encoder's view; the master modport is the view of the request source and command sink.
interface udma_i2c_cmd_enc_if #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic                      req_rnw_i;
    logic [6:0]                req_slv_addr_i;
    logic [L2_AWIDTH_NOAL-1:0] req_buf_addr_i;
    logic [TRANS_SIZE-1:0]     req_len_i;
    logic [15:0]               req_clkdiv_i;
    logic [31:0]               udma_cmd_o;
    logic                      udma_cmd_valid_o;
    logic                      udma_cmd_ready_i;

    modport slave (
        input  req_valid_i, req_rnw_i, req_slv_addr_i, req_buf_addr_i,
               req_len_i, req_clkdiv_i, udma_cmd_ready_i,
        output req_ready_o, udma_cmd_o, udma_cmd_valid_o
    );

    modport master (
        output req_valid_i, req_rnw_i, req_slv_addr_i, req_buf_addr_i,
               req_len_i, req_clkdiv_i, udma_cmd_ready_i,
        input  req_ready_o, udma_cmd_o, udma_cmd_valid_o
    );
endinterface

// File: rtl/udma_i2c_cmd_enc.sv
// Turns one I2C transfer request into the uDMA I2C command-word sequence on a registered valid/ready stream.
// Each state emits exactly one word; the state is left only when that word is accepted.
module udma_i2c_cmd_enc #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    udma_i2c_cmd_enc_if.slave  bus,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               aborted_o
);
    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_START, S_ADDR, S_UCA, S_UCS,
        S_RPT, S_DATA, S_LAST, S_STOP, S_EOT
    } state_t;

    state_t                    state_q, state_d, nxt;
    logic                      abort_q, abort_d;
    logic                      rnw_q, rnw_d;
    logic [6:0]                slv_q, slv_d;
    logic [L2_AWIDTH_NOAL-1:0] buf_q, buf_d;
    logic [TRANS_SIZE-1:0]     len_q, len_d;
    logic [15:0]               clkdiv_q, clkdiv_d;
    logic [31:0]               cmd_q, cmd_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;
    logic                      aborted_q, aborted_d;
    logic                      accept, abort_eff, multi;
    logic [TRANS_SIZE-1:0]     rpt_cnt;

    assign accept    = valid_q && bus.udma_cmd_ready_i;
    assign abort_eff = abort_q || abort_i;
    assign multi     = len_q > TRANS_SIZE'(1);
    // A read repeats RD_ACK one byte short; the final byte is the RD_NACK word.
    assign rpt_cnt   = rnw_q ? (len_q - TRANS_SIZE'(1)) : len_q;

    always_comb begin
        nxt = state_q;
        unique case (state_q)
            S_IDLE:  nxt = S_IDLE;
            S_CFG:   nxt = S_START;
            S_START: nxt = S_ADDR;
            S_ADDR:  nxt = (len_q == '0) ? S_STOP : S_UCA;
            S_UCA:   nxt = S_UCS;
            S_UCS:   nxt = multi ? S_RPT : (rnw_q ? S_LAST : S_DATA);
            S_RPT:   nxt = S_DATA;
            S_DATA:  nxt = rnw_q ? S_LAST : S_STOP;
            S_LAST:  nxt = S_STOP;
            S_STOP:  nxt = S_EOT;
            S_EOT:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (abort_eff && state_q != S_STOP && state_q != S_EOT && state_q != S_IDLE)
            nxt = S_STOP;
    end

    always_comb begin
        state_d   = state_q;
        abort_d   = abort_q;
        rnw_d     = rnw_q;
        slv_d     = slv_q;
        buf_d     = buf_q;
        len_d     = len_q;
        clkdiv_d  = clkdiv_q;
        cmd_d     = cmd_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (bus.req_valid_i) begin
                rnw_d    = bus.req_rnw_i;
                slv_d    = bus.req_slv_addr_i;
                buf_d    = bus.req_buf_addr_i;
                len_d    = bus.req_len_i;
                clkdiv_d = bus.req_clkdiv_i;
                state_d  = S_CFG;
                cmd_d    = {4'hE, 12'h0, bus.req_clkdiv_i};
                valid_d  = 1'b1;
            end
        end else begin
            if (abort_i)
                abort_d = 1'b1;
            if (accept) begin
                state_d = nxt;
                valid_d = 1'b1;
                unique case (nxt)
                    S_START: cmd_d = 32'h0000_0000;
                    S_ADDR:  cmd_d = {4'h7, 20'h0, slv_q, rnw_q};
                    S_UCA:   cmd_d = {4'h3, !rnw_q, 27'(buf_q)};
                    S_UCS:   cmd_d = {4'h5, !rnw_q, 11'h0, 16'(len_q)};
                    S_RPT:   cmd_d = {4'hC, 12'h0, 16'(rpt_cnt)};
                    S_DATA:  cmd_d = rnw_q ? 32'h4000_0000 : 32'h8000_0000;
                    S_LAST:  cmd_d = 32'h6000_0000;
                    S_STOP:  cmd_d = 32'h2000_0000;
                    S_EOT:   cmd_d = 32'h9000_0000;
                    default: begin
                        cmd_d     = 32'h0000_0000;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                        aborted_d = abort_eff;
                        abort_d   = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            abort_q   <= 1'b0;
            rnw_q     <= 1'b0;
            slv_q     <= '0;
            buf_q     <= '0;
            len_q     <= '0;
            clkdiv_q  <= '0;
            cmd_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            abort_q   <= abort_d;
            rnw_q     <= rnw_d;
            slv_q     <= slv_d;
            buf_q     <= buf_d;
            len_q     <= len_d;
            clkdiv_q  <= clkdiv_d;
            cmd_q     <= cmd_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.req_ready_o      = (state_q == S_IDLE);
    assign bus.udma_cmd_o       = cmd_q;
    assign bus.udma_cmd_valid_o = valid_q;
    assign busy_o               = (state_q != S_IDLE);
    assign done_o               = done_q;
    assign aborted_o            = aborted_q;
endmodule

// File: tb/tb_udma_i2c_cmd_enc.sv
// Bench for udma_i2c_cmd_enc: fixed vector table, hand-written corner sequences, and randomized
// requests with random back-pressure and aborts checked against a list-building reference model.
module tb_udma_i2c_cmd_enc;
    logic clk = 1'b0;
    logic rst, abort, busy, done, aborted;
    always #5 clk = ~clk;

    udma_i2c_cmd_enc_if #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) bus ();

    udma_i2c_cmd_enc #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .abort_i(abort),
        .busy_o(busy), .done_o(done), .aborted_o(aborted)
    );

    typedef struct {
        logic        rnw;
        logic [6:0]  slv;
        logic [11:0] ba;
        logic [15:0] len;
        logic [15:0] cd;
        int          n;
        logic [31:0] w[10];
    } vec_t;

    vec_t        vecs[4];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    int          gaps;
    bit          got_done, got_aborted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: the command list is written out directly from the transfer rules.
    task automatic model(input logic rnw, input logic [6:0] slv, input logic [11:0] ba,
                         input logic [15:0] len, input logic [15:0] cd);
        logic tx;
        tx = !rnw;
        exp_q.delete();
        exp_q.push_back({4'hE, 12'h0, cd});
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back({4'h7, 20'h0, slv, rnw});
        if (len != 0) begin
            exp_q.push_back({4'h3, tx, 15'h0, ba});
            exp_q.push_back({4'h5, tx, 11'h0, len});
            if (!rnw) begin
                if (len > 1) exp_q.push_back({4'hC, 12'h0, len});
                exp_q.push_back(32'h8000_0000);
            end else begin
                if (len > 1) begin
                    exp_q.push_back({4'hC, 12'h0, len - 16'd1});
                    exp_q.push_back(32'h4000_0000);
                end
                exp_q.push_back(32'h6000_0000);
            end
        end
        exp_q.push_back(32'h2000_0000);
        exp_q.push_back(32'h9000_0000);
    endtask

    // An abort raised before word j is accepted cuts the list after j, unless j is already STOP/EOT.
    task automatic model_abort(input int j);
        logic [31:0] keep[$];
        if (exp_q[j][31:28] != 4'h2 && exp_q[j][31:28] != 4'h9) begin
            keep = exp_q[0:j];
            exp_q = keep;
            exp_q.push_back(32'h2000_0000);
            exp_q.push_back(32'h9000_0000);
        end
    endtask

    task automatic send_req(input logic rnw, input logic [6:0] slv, input logic [11:0] ba,
                            input logic [15:0] len, input logic [15:0] cd);
        chk("req_ready_idle", {31'h0, bus.req_ready_o}, 32'd1);
        bus.req_valid_i    = 1'b1;
        bus.req_rnw_i      = rnw;
        bus.req_slv_addr_i = slv;
        bus.req_buf_addr_i = ba;
        bus.req_len_i      = len;
        bus.req_clkdiv_i   = cd;
        @(negedge clk);
        bus.req_valid_i    = 1'b0;
        bus.req_rnw_i      = 1'($urandom);
        bus.req_slv_addr_i = 7'($urandom);
        bus.req_buf_addr_i = 12'($urandom);
        bus.req_len_i      = 16'($urandom);
        bus.req_clkdiv_i   = 16'($urandom);
        chk("done_single_pulse", {31'h0, done}, 32'd0);
        chk("busy_after_req", {31'h0, busy}, 32'd1);
    endtask

    task automatic collect(input int ready_pct, input int abort_at);
        bit          held, fired, rdy;
        logic [31:0] held_word;
        int          stall_err, early_done;
        got_q.delete();
        gaps = 0; stall_err = 0; early_done = 0;
        held = 0; fired = 0; held_word = '0;
        got_done = 0; got_aborted = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            abort = 1'b0;
            if (held && (!bus.udma_cmd_valid_o || bus.udma_cmd_o !== held_word)) stall_err++;
            if (done) early_done++;
            if (!bus.udma_cmd_valid_o) gaps++;
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (abort_at >= 0 && !fired && got_q.size() == abort_at && bus.udma_cmd_valid_o) begin
                rdy = 1'b0; abort = 1'b1; fired = 1;
            end
            bus.udma_cmd_ready_i = rdy;
            held      = bus.udma_cmd_valid_o && !rdy;
            held_word = bus.udma_cmd_o;
            if (bus.udma_cmd_valid_o && rdy) begin
                got_q.push_back(bus.udma_cmd_o);
                if (bus.udma_cmd_o == 32'h9000_0000) begin
                    @(negedge clk);
                    bus.udma_cmd_ready_i = 1'b0;
                    got_done    = done;
                    got_aborted = aborted;
                    chk("ready_after_eot", {31'h0, bus.req_ready_o}, 32'd1);
                    chk("valid_after_eot", {31'h0, bus.udma_cmd_valid_o}, 32'd0);
                    chk("stall_stable", stall_err, 32'd0);
                    chk("no_early_done", early_done, 32'd0);
                    return;
                end
            end
            @(negedge clk);
        end
        chk("seq_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_seq(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) chk($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        vecs[0] = '{1'b0, 7'h50, 12'h100, 16'd4, 16'h0010, 9,
                    '{32'hE0000010, 32'h00000000, 32'h700000A0, 32'h38000100, 32'h58000004,
                      32'hC0000004, 32'h80000000, 32'h20000000, 32'h90000000, 32'h0}};
        vecs[1] = '{1'b1, 7'h21, 12'h200, 16'd3, 16'h0008, 10,
                    '{32'hE0000008, 32'h00000000, 32'h70000043, 32'h30000200, 32'h50000003,
                      32'hC0000002, 32'h40000000, 32'h60000000, 32'h20000000, 32'h90000000}};
        vecs[2] = '{1'b1, 7'h21, 12'h200, 16'd1, 16'h0008, 8,
                    '{32'hE0000008, 32'h00000000, 32'h70000043, 32'h30000200, 32'h50000001,
                      32'h60000000, 32'h20000000, 32'h90000000, 32'h0, 32'h0}};
        vecs[3] = '{1'b0, 7'h50, 12'h100, 16'd0, 16'h0010, 5,
                    '{32'hE0000010, 32'h00000000, 32'h700000A0, 32'h20000000, 32'h90000000,
                      32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

        rst = 1'b1; abort = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_rnw_i = 1'b0; bus.req_slv_addr_i = '0;
        bus.req_buf_addr_i = '0; bus.req_len_i = '0; bus.req_clkdiv_i = '0;
        bus.udma_cmd_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'h0, bus.udma_cmd_valid_o}, 32'd0);
        chk("rst_cmd", bus.udma_cmd_o, 32'd0);
        chk("rst_req_ready", {31'h0, bus.req_ready_o}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_aborted", {31'h0, aborted}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Vector table, ready held high, requests issued back to back.
        for (int v = 0; v < 4; v++) begin
            send_req(vecs[v].rnw, vecs[v].slv, vecs[v].ba, vecs[v].len, vecs[v].cd);
            collect(100, -1);
            exp_q.delete();
            for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].w[i]);
            compare_seq($sformatf("vec%0d", v));
            chk("vec_no_gaps", gaps, 32'd0);
            chk("vec_done", {31'h0, got_done}, 32'd1);
            chk("vec_not_aborted", {31'h0, got_aborted}, 32'd0);
        end

        // Back-pressure on the N=4 write.
        send_req(1'b0, 7'h50, 12'h100, 16'd4, 16'h0010);
        collect(45, -1);
        model(1'b0, 7'h50, 12'h100, 16'd4, 16'h0010);
        compare_seq("bp");
        chk("bp_done", {31'h0, got_done}, 32'd1);

        // Abort pulsed while the UCA word is stalled.
        send_req(1'b0, 7'h50, 12'h100, 16'd4, 16'h0010);
        collect(100, 3);
        exp_q = '{32'hE0000010, 32'h00000000, 32'h700000A0, 32'h38000100, 32'h20000000, 32'h90000000};
        compare_seq("abort");
        chk("abort_done", {31'h0, got_done}, 32'd1);
        chk("abort_aborted", {31'h0, got_aborted}, 32'd1);

        // Abort in IDLE is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        send_req(1'b1, 7'h11, 12'h0, 16'd0, 16'h0003);
        collect(100, -1);
        model(1'b1, 7'h11, 12'h0, 16'd0, 16'h0003);
        compare_seq("idle_abort");
        chk("idle_abort_flag", {31'h0, got_aborted}, 32'd0);

        // Reset while UCS is valid.
        send_req(1'b0, 7'h50, 12'h100, 16'd4, 16'h0010);
        bus.udma_cmd_ready_i = 1'b1;
        for (int c = 0; c < 20 && !(bus.udma_cmd_valid_o && bus.udma_cmd_o == 32'h58000004); c++)
            @(negedge clk);
        chk("rst_mid_reached_ucs", bus.udma_cmd_o, 32'h58000004);
        bus.udma_cmd_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", {31'h0, bus.udma_cmd_valid_o}, 32'd0);
        chk("rst_mid_busy", {31'h0, busy}, 32'd0);
        chk("rst_mid_ready", {31'h0, bus.req_ready_o}, 32'd1);
        chk("rst_mid_done", {31'h0, done}, 32'd0);
        send_req(1'b1, 7'h3A, 12'hABC, 16'd2, 16'h1234);
        collect(100, -1);
        model(1'b1, 7'h3A, 12'hABC, 16'd2, 16'h1234);
        compare_seq("after_rst");

        // Randomized requests, back-pressure and aborts.
        for (int t = 0; t < 40; t++) begin
            logic        rnw;
            logic [6:0]  slv;
            logic [11:0] ba;
            logic [15:0] len, cd;
            int          ab, pct;
            rnw = 1'($urandom);
            slv = 7'($urandom);
            ba  = 12'($urandom);
            cd  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       len = 16'($urandom_range(0, 1));
                1:       len = 16'd2;
                2:       len = 16'($urandom);
                default: len = 16'($urandom_range(3, 8));
            endcase
            pct = $urandom_range(30, 100);
            model(rnw, slv, ba, len, cd);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, exp_q.size() - 3) : -1;
            if (ab >= 0) model_abort(ab);
            send_req(rnw, slv, ba, len, cd);
            collect(pct, ab);
            compare_seq($sformatf("rnd%0d", t));
            chk("rnd_done", {31'h0, got_done}, 32'd1);
            chk("rnd_aborted", {31'h0, got_aborted}, {31'h0, ab >= 0});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
